async_fifo_gray_param: RTL and testbench

Dual-clock FIFO with fully parametrised data width, depth and synchroniser length. It uses (ADDR_W+1)-bit binary/Gray pointers, so no separate toggle flags are needed. Adds per-domain fill counts, programmable almost_full/almost_empty and sticky overflow/underflow. It is the standard clock-domain-crossing buffer between a w_clk producer and an r_clk consumer.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/gray_ptr_sync.sv | 25 ++
 rtl/async_fifo_gray_param.sv | 139 +++++++++++++
 tb/tb_async_fifo_gray_param.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the Gray-pointer FIFO: Gray/binary conversion and depth.
// Conversions work on 32 bits; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

  localparam int CONV_W = 32;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// N-bit multi-flop synchroniser with synchronous reset; used for Gray pointers
// and, with N=1, for the read-domain reset.
module gray_ptr_sync #(
  parameter int N      = 5,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [STAGES-1:0][N-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_fifo_gray_param.sv
// Dual-clock FIFO using (ADDR_W+1)-bit binary/Gray pointers, per-domain
// conservative fill counts, almost flags and sticky overflow/underflow.
module async_fifo_gray_param
  import fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LVL   = (1 << ADDR_W) - 2,
  parameter int AEMPTY_LVL  = 2
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              r_clk,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              almost_empty,
  output logic              underflow,
  output logic [ADDR_W:0]   rd_count
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int PTR_W = ADDR_W + 1;
  // Full when the other pointer equals ours with the two Gray MSBs inverted.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_W - 1);
  localparam logic [PTR_W-1:0] AFULL_C   = PTR_W'(AFULL_LVL);
  localparam logic [PTR_W-1:0] AEMPTY_C  = PTR_W'(AEMPTY_LVL);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wptr, r_wgray, w_wptr_next, w_wgray_next;
  logic [PTR_W-1:0] w_rgray_sync, w_rptr_in_w, w_wr_count_next;
  logic             r_full, r_almost_full, r_overflow;
  logic [PTR_W-1:0] r_wr_count;
  logic             w_wr_ok;

  logic [PTR_W-1:0] r_rptr, r_rgray, w_rptr_next, w_rgray_next;
  logic [PTR_W-1:0] w_wgray_sync, w_wptr_in_r, w_rd_count_next;
  logic             r_empty, r_almost_empty, r_underflow;
  logic [PTR_W-1:0] r_rd_count;
  logic [DATA_W-1:0] r_rdata;
  logic             w_rd_ok;
  logic             w_rd_rst;

  gray_ptr_sync #(.N(1), .STAGES(SYNC_STAGES)) u_rst_sync (
    .i_clk (r_clk),
    .i_rst (1'b0),
    .i_d   (rst),
    .o_q   (w_rd_rst)
  );

  gray_ptr_sync #(.N(PTR_W), .STAGES(SYNC_STAGES)) u_rgray_sync (
    .i_clk (w_clk),
    .i_rst (rst),
    .i_d   (r_rgray),
    .o_q   (w_rgray_sync)
  );

  gray_ptr_sync #(.N(PTR_W), .STAGES(SYNC_STAGES)) u_wgray_sync (
    .i_clk (r_clk),
    .i_rst (w_rd_rst),
    .i_d   (r_wgray),
    .o_q   (w_wgray_sync)
  );

  // Write domain
  assign w_wr_ok         = wr_en && !r_full;
  assign w_wptr_next     = r_wptr + PTR_W'(w_wr_ok);
  assign w_wgray_next    = PTR_W'(bin2gray(32'(w_wptr_next)));
  assign w_rptr_in_w     = PTR_W'(gray2bin(32'(w_rgray_sync)));
  assign w_wr_count_next = w_wptr_next - w_rptr_in_w;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_wgray       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_wr_count    <= '0;
    end else begin
      r_wptr        <= w_wptr_next;
      r_wgray       <= w_wgray_next;
      r_full        <= (w_wgray_next == (w_rgray_sync ^ FULL_MASK));
      r_almost_full <= (w_wr_count_next >= AFULL_C);
      r_wr_count    <= w_wr_count_next;
      if (wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!rst && w_wr_ok) r_mem[r_wptr[ADDR_W-1:0]] <= wdata;
  end

  // Read domain
  assign w_rd_ok         = rd_en && !r_empty;
  assign w_rptr_next     = r_rptr + PTR_W'(w_rd_ok);
  assign w_rgray_next    = PTR_W'(bin2gray(32'(w_rptr_next)));
  assign w_wptr_in_r     = PTR_W'(gray2bin(32'(w_wgray_sync)));
  assign w_rd_count_next = w_wptr_in_r - w_rptr_next;

  always_ff @(posedge r_clk) begin
    if (w_rd_rst) begin
      r_rptr         <= '0;
      r_rgray        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
      r_rd_count     <= '0;
      r_rdata        <= '0;
    end else begin
      r_rptr         <= w_rptr_next;
      r_rgray        <= w_rgray_next;
      r_empty        <= (w_rgray_next == w_wgray_sync);
      r_almost_empty <= (w_rd_count_next <= AEMPTY_C);
      r_rd_count     <= w_rd_count_next;
      if (w_rd_ok) r_rdata <= r_mem[r_rptr[ADDR_W-1:0]];
      if (rd_en && r_empty) r_underflow <= 1'b1;
    end
  end

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign overflow     = r_overflow;
  assign wr_count     = r_wr_count;
  assign rdata        = r_rdata;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign underflow    = r_underflow;
  assign rd_count     = r_rd_count;

endmodule

// File: tb/tb_async_fifo_gray_param.sv
// Directed bench for async_fifo_gray_param: reset, fill, drain, wrap,
// random streaming against a queue, and reset while data is stored.
module tb_async_fifo_gray_param;

  logic       w_clk, r_clk, rst;
  logic       wr_en, rd_en;
  logic [7:0] wdata, rdata;
  logic       full, almost_full, overflow;
  logic       empty, almost_empty, underflow;
  logic [4:0] wr_count, rd_count;

  int checks = 0;
  int errors = 0;

  async_fifo_gray_param #(
    .DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2), .AFULL_LVL(14), .AEMPTY_LVL(2)
  ) dut (
    .w_clk(w_clk), .rst(rst), .r_clk(r_clk),
    .wr_en(wr_en), .wdata(wdata), .full(full), .almost_full(almost_full),
    .overflow(overflow), .wr_count(wr_count),
    .rd_en(rd_en), .rdata(rdata), .empty(empty), .almost_empty(almost_empty),
    .underflow(underflow), .rd_count(rd_count)
  );

  initial begin
    w_clk = 0;
    forever #5 w_clk = ~w_clk;
  end

  initial begin
    r_clk = 0;
    #2;
    forever begin
      #8 r_clk = 1;
      #9 r_clk = 0;
    end
  end

  task automatic write_word(input logic [7:0] d);
    @(negedge w_clk);
    wr_en = 1;
    wdata = d;
    @(posedge w_clk);
    #1;
    wr_en = 0;
  endtask

  task automatic read_word();
    @(negedge r_clk);
    rd_en = 1;
    @(posedge r_clk);
    #1;
    rd_en = 0;
  endtask

  task automatic wait_rd_count(input logic [4:0] n);
    for (int k = 0; k < 40; k++) begin
      @(posedge r_clk);
      #1;
      if (rd_count == n) break;
    end
  endtask

  task automatic wait_wr_count(input logic [4:0] n);
    for (int k = 0; k < 60; k++) begin
      @(posedge w_clk);
      #1;
      if (wr_count == n) break;
    end
  endtask

  task automatic apply_reset();
    rst = 1;
    repeat (3) @(posedge w_clk);
    #1;
    rst = 0;
    repeat (8) @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
    checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
    checks++; if (rd_count !== 5'd0) begin errors++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_sticky: got ovf=%b unf=%b expected 0/0", overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      write_word(8'(i));
      if (i == 12 || i == 13) begin
        checks++;
        if (almost_full !== (i == 13)) begin
          errors++; $display("FAIL fill_almost_full_w%0d: got %b expected %b", i + 1, almost_full, i == 13);
        end
      end
      if (i >= 14) begin
        checks++;
        if (full !== (i == 15)) begin
          errors++; $display("FAIL fill_full_w%0d: got %b expected %b", i + 1, full, i == 15);
        end
      end
    end
    checks++; if (wr_count !== 5'd16) begin errors++; $display("FAIL fill_wr_count: got %0d expected 16", wr_count); end
    write_word(8'hEE);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
    checks++; if (wr_count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL fill_held: got count=%0d full=%b expected 16/1", wr_count, full);
    end
  endtask

  task automatic test_drain();
    wait_rd_count(5'd16);
    checks++; if (rd_count !== 5'd16 || empty !== 1'b0) begin
      errors++; $display("FAIL drain_seen: got count=%0d empty=%b expected 16/0", rd_count, empty);
    end
    for (int i = 0; i < 16; i++) begin
      read_word();
      checks++;
      if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", i, rdata, 8'(i)); end
      if (i == 12 || i == 13) begin
        checks++;
        if (almost_empty !== (i == 13)) begin
          errors++; $display("FAIL drain_almost_empty_r%0d: got %b expected %b", i + 1, almost_empty, i == 13);
        end
      end
      if (i >= 14) begin
        checks++;
        if (empty !== (i == 15)) begin
          errors++; $display("FAIL drain_empty_r%0d: got %b expected %b", i + 1, empty, i == 15);
        end
      end
    end
    read_word();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow: got %b expected 1", underflow); end
    checks++; if (rdata !== 8'h0F) begin errors++; $display("FAIL drain_rdata_hold: got %h expected 0f", rdata); end
    wait_wr_count(5'd0);
    checks++; if (full !== 1'b0 || wr_count !== 5'd0) begin
      errors++; $display("FAIL drain_space_back: got full=%b count=%0d expected 0/0", full, wr_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) write_word(8'h10 + 8'(i));
    wait_rd_count(5'd10);
    for (int i = 0; i < 10; i++) begin
      read_word();
      checks++;
      if (rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL wrap_pre_%0d: got %h expected %h", i, rdata, 8'h10 + 8'(i)); end
    end
    wait_wr_count(5'd0);
    for (int i = 0; i < 16; i++) begin
      write_word(8'hA0 + 8'(i));
      if (i >= 14) begin
        checks++;
        if (full !== (i == 15)) begin errors++; $display("FAIL wrap_full_w%0d: got %b expected %b", i + 1, full, i == 15); end
      end
    end
    wait_rd_count(5'd16);
    for (int i = 0; i < 16; i++) begin
      read_word();
      checks++;
      if (rdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wrap_data_%0d: got %h expected %h", i, rdata, 8'hA0 + 8'(i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_streaming();
    logic [7:0] q[$];
    logic       bad_w, bad_r;
    int         sent, got, wcyc, rcyc;
    bad_w = 0; bad_r = 0; sent = 0; got = 0; wcyc = 0; rcyc = 0;
    apply_reset();
    fork
      begin
        while (sent < 2000 && wcyc < 30000) begin
          @(negedge w_clk);
          wcyc++;
          if (wr_count > 5'd16) bad_w = 1;
          if (!full && $urandom_range(0, 1) == 1) begin
            wr_en = 1;
            wdata = 8'($urandom_range(0, 255));
            q.push_back(wdata);
            sent++;
          end else begin
            wr_en = 0;
          end
        end
        @(negedge w_clk);
        wr_en = 0;
      end
      begin
        while (got < 2000 && rcyc < 30000) begin
          logic did;
          logic [7:0] exp;
          @(negedge r_clk);
          rcyc++;
          if (rd_count > 5'd16) bad_r = 1;
          did = !empty && ($urandom_range(0, 3) != 0);
          rd_en = did;
          @(posedge r_clk);
          #1;
          rd_en = 0;
          if (did) begin
            exp = (q.size() > 0) ? q.pop_front() : 8'hXX;
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL stream_data_%0d: got %h expected %h", got, rdata, exp); end
            got++;
          end
        end
      end
    join
    checks++; if (got != 2000 || sent != 2000) begin
      errors++; $display("FAIL stream_done: got sent=%0d read=%0d expected 2000/2000", sent, got);
    end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL stream_sticky: got ovf=%b unf=%b expected 0/0", overflow, underflow);
    end
    checks++; if (bad_w || bad_r) begin
      errors++; $display("FAIL stream_count_range: got wr_over=%b rd_over=%b expected 0/0", bad_w, bad_r);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    read_word();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mid_underflow_set: got %b expected 1", underflow); end
    for (int i = 0; i < 5; i++) write_word(8'h30 + 8'(i));
    wait_rd_count(5'd5);
    checks++; if (rd_count !== 5'd5 || empty !== 1'b0) begin
      errors++; $display("FAIL mid_stored: got count=%0d empty=%b expected 5/0", rd_count, empty);
    end
    seen = 0;
    @(negedge w_clk);
    rst = 1;
    fork
      begin
        repeat (3) @(posedge w_clk);
        #1;
        rst = 0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(posedge r_clk);
          #1;
          if (empty) seen = 1;
        end
      end
    join
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_empty_fast: got %b expected 1", seen); end
    repeat (8) @(posedge r_clk);
    #1;
    checks++; if (empty !== 1'b1 || almost_empty !== 1'b1 || rd_count !== 5'd0 || underflow !== 1'b0) begin
      errors++; $display("FAIL mid_rd_cleared: got e=%b ae=%b cnt=%0d unf=%b expected 1/1/0/0", empty, almost_empty, rd_count, underflow);
    end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0 || wr_count !== 5'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_wr_cleared: got f=%b af=%b cnt=%0d ovf=%b expected 0/0/0/0", full, almost_full, wr_count, overflow);
    end
    write_word(8'h55);
    wait_rd_count(5'd1);
    read_word();
    checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL mid_first_word: got %h expected 55", rdata); end
  endtask

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; wdata = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_streaming();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
